// File: rtl/load_unit.sv
// Execute-stage load unit: computes rs1+imm, issues a single word read to
// data memory, waits MEM_LAT cycles, then extends and writes back the
// selected byte/half/word. Stalls the PC while the access is in flight.
module load_unit #(
    parameter int MEM_LAT = 1,   // read latency in cycles, 1..3
    parameter int ADDR_W  = 10   // word-address width
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              load_valid,
    input  logic [2:0]        load_control,
    input  logic [31:0]       rs1_val,
    input  logic [31:0]       imm,
    input  logic [31:0]       mem_read_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rd_we,
    output logic [31:0]       rd_val,
    output logic              load_misaligned,
    output logic              stall_pc,
    output logic              stall_other_exec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] C_LB  = 3'b000;
    localparam logic [2:0] C_LH  = 3'b001;
    localparam logic [2:0] C_LW  = 3'b010;
    localparam logic [2:0] C_LBU = 3'b100;
    localparam logic [2:0] C_LHU = 3'b101;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_off;
    logic [2:0]          r_ctrl;
    logic [1:0]          r_cnt;
    logic [31:0]         r_data;
    logic                r_misal;

    logic [31:0]         w_ea;
    logic                w_rsvd;
    logic                w_accept;
    logic                w_mis;
    logic                w_go;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_ext;
    logic                w_unused_ea;

    assign w_ea        = rs1_val + imm;
    // Bits above the word address are deliberately dropped.
    assign w_unused_ea = &{1'b0, w_ea[31:ADDR_W+2]};

    // Decode the request: reserved codes never start anything.
    always_comb begin
        w_rsvd   = !(load_control == C_LB  || load_control == C_LH ||
                     load_control == C_LW  || load_control == C_LBU ||
                     load_control == C_LHU);
        w_accept = (r_state == S_IDLE) && load_valid && !w_rsvd;
        w_mis    = ((load_control[1:0] == 2'b01) && w_ea[0]) ||
                   ((load_control == C_LW) && (w_ea[1:0] != 2'b00));
        w_go     = w_accept && !w_mis;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_nxt      = r_state;
        mem_rd_en        = 1'b0;
        stall_pc         = 1'b0;
        stall_other_exec = 1'b0;
        rd_we            = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_pc = w_go;
                if (w_go) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                mem_rd_en   = 1'b1;
                stall_pc    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                stall_pc = 1'b1;
                if (r_cnt == 2'd1) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                rd_we            = 1'b1;
                stall_other_exec = 1'b1;
                w_state_nxt      = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request latch, latency counter, data capture and misalign pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= '0;
            r_off   <= '0;
            r_ctrl  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_misal <= 1'b0;
        end else begin
            r_misal <= w_accept && w_mis;
            if (w_go) begin
                r_addr <= w_ea[ADDR_W+1:2];
                r_off  <= w_ea[1:0];
                r_ctrl <= load_control;
            end
            if (r_state == S_ISSUE) r_cnt <= 2'(MEM_LAT);
            else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 2'd1;
                if (r_cnt == 2'd1) r_data <= mem_read_data;
            end
        end
    end

    // Lane select and sign/zero extension of the captured word.
    always_comb begin
        case (r_off)
            2'd0:    w_byte = r_data[7:0];
            2'd1:    w_byte = r_data[15:8];
            2'd2:    w_byte = r_data[23:16];
            default: w_byte = r_data[31:24];
        endcase
        w_half = r_off[1] ? r_data[31:16] : r_data[15:0];
        case (r_ctrl)
            C_LB:    w_ext = {{24{w_byte[7]}}, w_byte};
            C_LH:    w_ext = {{16{w_half[15]}}, w_half};
            C_LW:    w_ext = r_data;
            C_LBU:   w_ext = {24'd0, w_byte};
            C_LHU:   w_ext = {16'd0, w_half};
            default: w_ext = '0;
        endcase
    end

    assign rd_val          = rd_we ? w_ext : 32'd0;
    assign mem_addr        = (r_state == S_IDLE) ? '0 : r_addr;
    assign load_misaligned = r_misal;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: one instance at default latency, one at
// MEM_LAT=3. Each has a small memory model returning the word exactly
// MEM_LAT cycles after its read strobe (zero otherwise).
module tb_load_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [2:0]  load_control = 3'b000;
    logic [31:0] rs1_val = '0;
    logic [31:0] imm = '0;
    logic [31:0] mem_word = '0;

    logic [31:0] mrd1, mrd3;
    logic        rd_en1, rd_we1, mis1, spc1, soe1;
    logic [9:0]  addr1;
    logic [31:0] val1;
    logic        rd_en3, rd_we3, mis3, spc3, soe3;
    logic [9:0]  addr3;
    logic [31:0] val3;

    logic        d1;
    logic [2:0]  p3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 i_clk = ~i_clk;

    load_unit #(.MEM_LAT(1), .ADDR_W(10)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .load_valid(load_valid),
        .load_control(load_control), .rs1_val(rs1_val), .imm(imm),
        .mem_read_data(mrd1), .mem_rd_en(rd_en1), .mem_addr(addr1),
        .rd_we(rd_we1), .rd_val(val1), .load_misaligned(mis1),
        .stall_pc(spc1), .stall_other_exec(soe1));

    load_unit #(.MEM_LAT(3), .ADDR_W(10)) dut3 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .load_valid(load_valid),
        .load_control(load_control), .rs1_val(rs1_val), .imm(imm),
        .mem_read_data(mrd3), .mem_rd_en(rd_en3), .mem_addr(addr3),
        .rd_we(rd_we3), .rd_val(val3), .load_misaligned(mis3),
        .stall_pc(spc3), .stall_other_exec(soe3));

    // Memory models: data valid only in the cycle MEM_LAT after the strobe.
    always @(posedge i_clk) begin
        d1 <= rd_en1;
        p3 <= {p3[1:0], rd_en3};
    end
    initial begin d1 = 1'b0; p3 = '0; end
    assign mrd1 = d1    ? mem_word : 32'h0;
    assign mrd3 = p3[2] ? mem_word : 32'h0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to mid-cycle of the next clock cycle.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    function automatic logic [63:0] outs1();
        return {rd_en1, addr1, rd_we1, val1, mis1, spc1, soe1};
    endfunction

    task automatic do_reset();
        i_rst_n = 1'b0;
        load_valid = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    // Single load on dut: cycle 0 request, expect result in cycle 3.
    task automatic do_load(input string tag, input logic [2:0] c,
                           input logic [31:0] r, input logic [31:0] i,
                           input logic [31:0] w, input logic [31:0] exp);
        mem_word = w;
        load_valid = 1'b1; load_control = c; rs1_val = r; imm = i;
        #1;
        chk({tag, " stall c0"}, spc1, 1'b1);
        tick();
        load_valid = 1'b0;
        chk({tag, " rd_en c1"}, rd_en1, 1'b1);
        tick();
        chk({tag, " wait c2"}, {rd_en1, rd_we1, spc1}, 3'b001);
        tick();
        chk({tag, " wb c3"}, {rd_we1, val1, spc1, soe1}, {1'b1, exp, 1'b0, 1'b1});
        tick();
        chk({tag, " idle c4"}, outs1(), 64'd0);
    endtask

    // Request that must produce no access; misaligned pulse expected or not.
    task automatic no_access(input string tag, input logic [2:0] c,
                             input logic [31:0] r, input logic [31:0] i,
                             input logic exp_mis);
        load_valid = 1'b1; load_control = c; rs1_val = r; imm = i;
        #1;
        chk({tag, " c0"}, {spc1, rd_en1, mis1}, 3'b000);
        tick();
        load_valid = 1'b0;
        chk({tag, " pulse"}, {mis1, rd_en1, rd_we1, spc1}, {exp_mis, 3'b000});
        tick();
        chk({tag, " after"}, outs1(), 64'd0);
        tick();
        chk({tag, " quiet"}, outs1(), 64'd0);
    endtask

    initial begin
        int first_en, second_en, we_cnt, we_a, we_b;

        // Reset and idle.
        #1;
        chk("in reset", outs1(), 64'd0);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            chk("idle outs", outs1(), 64'd0);
            tick();
        end

        // LW with detailed timing.
        mem_word = 32'hDEADBEEF;
        load_valid = 1'b1; load_control = 3'b010; rs1_val = 32'h100; imm = 32'h4;
        #1;
        chk("lw c0 stall", {spc1, rd_en1, soe1}, 3'b100);
        tick();
        load_valid = 1'b0;
        chk("lw c1 issue", {rd_en1, addr1, spc1}, {1'b1, 10'h041, 1'b1});
        tick();
        chk("lw c2 wait", {rd_en1, addr1, spc1, rd_we1}, {1'b0, 10'h041, 1'b1, 1'b0});
        tick();
        chk("lw c3 wb", {rd_we1, val1, spc1, soe1}, {1'b1, 32'hDEADBEEF, 1'b0, 1'b1});
        tick();
        chk("lw c4 idle", outs1(), 64'd0);

        // Extraction and extension.
        do_load("lb off2",  3'b000, 32'h200, 32'h2, 32'h80FF7F01, 32'hFFFFFFFF);
        do_load("lb off3",  3'b000, 32'h200, 32'h3, 32'h80FF7F01, 32'hFFFFFF80);
        do_load("lbu off3", 3'b100, 32'h200, 32'h3, 32'h80FF7F01, 32'h00000080);
        do_load("lb off1",  3'b000, 32'h200, 32'h1, 32'h80FF7F01, 32'h0000007F);
        do_load("lh off2",  3'b001, 32'h200, 32'h2, 32'h80FF7F01, 32'hFFFF80FF);
        do_load("lhu off0", 3'b101, 32'h210, 32'hFFFFFFF0, 32'h80FF7F01, 32'h00007F01);
        do_load("lhu off2", 3'b101, 32'h200, 32'h2, 32'h80FF7F01, 32'h000080FF);

        // Misaligned and reserved requests.
        no_access("lw mis", 3'b010, 32'h100, 32'h2, 1'b1);
        no_access("lh mis", 3'b001, 32'h100, 32'h3, 1'b1);
        no_access("rsvd",   3'b011, 32'h100, 32'h0, 1'b0);

        // Back-to-back on MEM_LAT=3 with load_valid held.
        do_reset();
        mem_word = 32'h12345678;
        load_valid = 1'b1; load_control = 3'b010; rs1_val = 32'h40; imm = 32'h0;
        first_en = -1; second_en = -1; we_cnt = 0; we_a = -1; we_b = -1;
        #1;
        for (int k = 0; k < 14; k++) begin
            if (rd_en3) begin
                if (first_en < 0) first_en = k;
                else if (second_en < 0) second_en = k;
            end
            if (rd_we3) begin
                we_cnt++;
                if (we_a < 0) we_a = k; else if (we_b < 0) we_b = k;
                chk("b2b rd_val", val3, 32'h12345678);
            end
            tick();
            #1;
        end
        load_valid = 1'b0;
        chk("b2b first en", first_en, 1);
        chk("b2b en gap", second_en - first_en, 6);
        chk("b2b we count", we_cnt, 2);
        chk("b2b we cycles", {we_a[15:0], we_b[15:0]}, {16'd5, 16'd11});

        // Reset during WAIT.
        do_reset();
        mem_word = 32'hCAFEF00D;
        load_valid = 1'b1; load_control = 3'b010; rs1_val = 32'h80; imm = 32'h0;
        tick();
        load_valid = 1'b0;
        tick();
        chk("pre-rst wait", spc1, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk("rst async", outs1(), 64'd0);
        tick();
        i_rst_n = 1'b1;
        we_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rd_we1) we_cnt++;
        end
        chk("rst no wb", we_cnt, 0);
        do_load("post-rst lw", 3'b010, 32'h80, 32'h4, 32'h0BADCAFE, 32'h0BADCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
